avs_array_mem_responder: RTL and testbench
==========================================

// Module: avs_array_mem_responder
// PURPOSE
//  Avalon-MM slave responder serving one kernel array port (A, x or y) of the atax accelerator.
//  Holds the array in on-chip RAM and answers master read/write with waitrequest, byteenable and programmable wait states.
//  A secondary host port preloads and reads back the array while the accelerator is idle.
//  Sticky error and access-count status supports bring-up.
// PARAMETERS
//  DATA_W       64  data bus width in bits (BE_W = DATA_W/8 byte lanes)
//  ADDR_W       13  avs byte-address width; RAM depth = 2**ADDR_W / BE_W words
//  WAIT_STATES   1  waitrequest-high cycles per access; legal range 1..15
// PORTS
//  clk             in   1            clock
//  reset           in   1            asynchronous, active-high
//  avs_read        in   1            master read request
//  avs_write       in   1            master write request
//  avs_address     in   ADDR_W       byte address; word index = address >> log2(BE_W)
//  avs_writedata   in   DATA_W       write data
//  avs_byteenable  in   BE_W         per-byte write enable
//  avs_waitrequest out  1            stall; transfer completes in a cycle with request high and waitrequest low
//  avs_readdata    out  DATA_W       read data, valid in the completing cycle
//  host_req        in   1            host access request (one-cycle pulse or held)
//  host_we         in   1            host write (1) / read (0)
//  host_addr       in   ADDR_W-log2(BE_W)  host word address
//  host_wdata      in   DATA_W       host write data (full word)
//  host_rdata      out  DATA_W       host read data, valid with host_ack
//  host_ack        out  1            one-cycle completion pulse
//  rd_count        out  32           completed avs reads, saturating
//  wr_count        out  32           completed avs writes, saturating
//  misalign_err    out  1            sticky: avs access had nonzero low address bits
// BEHAVIOUR
//  Reset values
//  - FSM = IDLE; avs_readdata = 0; host_rdata = 0; host_ack = 0; counts = 0; misalign_err = 0.
//  - RAM contents are not reset.
//  - avs_waitrequest = 1 while reset is asserted.
//  avs_waitrequest
//  - Combinational: (avs_read | avs_write) & (state != ACK).
//  - Therefore 0 when there is no request.
//  FSM states: IDLE, WAIT, ACK, HOST
//  - IDLE, avs request: latch word address, writedata and byteenable; load cnt = WAIT_STATES-1.
//    Go to ACK if cnt == 0, else WAIT.
//  - WAIT: cnt decrements each cycle; go to ACK when cnt reaches 0.
//    If the master drops both read and write in WAIT: return to IDLE with no commit and no count.
//  - Read timing: RAM read uses the latched address in the cycle before ACK. The registered output appears on avs_readdata in ACK.
//    Total waitrequest-high cycles = WAIT_STATES.
//  - ACK: waitrequest 0.
//    A write commits at the end of ACK, one byte per byteenable bit; wr_count++.
//    A read increments rd_count.
//    Next state is IDLE; back-to-back requests restart from IDLE.
//  - Simultaneous read and write: treated as a write.
//  - IDLE, no avs request, host_req: go to HOST and latch the host command.
//    HOST does the RAM access; host_ack = 1 and host_rdata valid in the following cycle.
//    A host write updates the full word. Then return to IDLE.
//  - avs has priority: a host request arriving with an avs request stays pending.
//    host_req must stay high until accepted. Accepted = the FSM enters HOST; the request is sampled only in IDLE.
//  Misalignment
//  - avs_address[log2(BE_W)-1:0] != 0 sets misalign_err (cleared only by reset).
//  - The access still proceeds at the truncated word address.
//  Counters
//  - Count only in ACK and saturate at 32'hFFFF_FFFF.
//  Reset mid-operation
//  - Abort to IDLE; no write commits; no ack.
//  Notes
//  - avs_readdata holds its last value outside ACK.
//  - Addresses wrap inside RAM depth only through truncation; there is no out-of-range detection.
// TESTING
//  1 Read latency: host writes word 5 = 64'h1122334455667788; WAIT_STATES=2; avs_read at address 13'h028.
//    -> waitrequest high 2 cycles, low on the 3rd; readdata = 64'h1122334455667788; rd_count = 1.
//  2 Byte-enable write: word 5 = 64'h1122334455667788; avs_write with data 64'hAAAAAAAAAAAAAAAA, byteenable 8'h0F.
//    -> host read of word 5 returns 64'h11223344AAAAAAAA; wr_count = 1.
//  3 Arbitration: host_req (read, word 0) and avs_read asserted in the same IDLE cycle.
//    -> avs completes first; host_ack occurs 2 cycles after the avs ACK cycle; no data corruption.
//  4 Misalignment: avs_read at address 13'h02B.
//    -> misalign_err = 1 and stays set; readdata = word 5; later aligned accesses keep misalign_err = 1.
//  5 Abort cases, each on its own: reset asserted in WAIT of a write to word 7, and avs_write dropped during WAIT (WAIT_STATES=3).
//    -> word 7 unchanged in both cases; after reset state = IDLE and counts = 0; wr_count is not incremented by the dropped write.

Source files
------------

// File: rtl/avs_array_mem_responder_if.sv
// Avalon-MM slave bus plus host preload port for one
// atax kernel array memory.
interface avs_array_mem_responder_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 13
);
    localparam int BE_W = DATA_W / 8;
    localparam int HA_W = ADDR_W - $clog2(BE_W);

    logic              avs_read;
    logic              avs_write;
    logic [ADDR_W-1:0] avs_address;
    logic [DATA_W-1:0] avs_writedata;
    logic [BE_W-1:0]   avs_byteenable;
    logic              avs_waitrequest;
    logic [DATA_W-1:0] avs_readdata;

    logic              host_req;
    logic              host_we;
    logic [HA_W-1:0]   host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic [DATA_W-1:0] host_rdata;
    logic              host_ack;

    modport slave (
        input  avs_read, avs_write, avs_address,
        input  avs_writedata, avs_byteenable,
        output avs_waitrequest, avs_readdata,
        input  host_req, host_we, host_addr, host_wdata,
        output host_rdata, host_ack
    );

    modport master (
        output avs_read, avs_write, avs_address,
        output avs_writedata, avs_byteenable,
        input  avs_waitrequest, avs_readdata,
        output host_req, host_we, host_addr, host_wdata,
        input  host_rdata, host_ack
    );
endinterface

// File: rtl/avs_array_mem_responder.sv
// Avalon-MM array memory responder with programmable wait
// states, host preload port and bring-up status.
module avs_array_mem_responder #(
    parameter int DATA_W      = 64,
    parameter int ADDR_W      = 13,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset,
    avs_array_mem_responder_if.slave bus,
    output logic [31:0] rd_count,
    output logic [31:0] wr_count,
    output logic        misalign_err
);
    localparam int BE_W  = DATA_W / 8;
    localparam int OFF_W = $clog2(BE_W);
    localparam int WA_W  = ADDR_W - OFF_W;
    localparam int DEPTH = 2 ** WA_W;
    localparam logic [3:0] CNT_INIT = 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {
        S_IDLE, S_WAIT, S_ACK, S_HOST
    } state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [WA_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [BE_W-1:0]   be_q, be_d;
    logic              we_q, we_d;
    logic [WA_W-1:0]   haddr_q, haddr_d;
    logic [DATA_W-1:0] hwdata_q, hwdata_d;
    logic              hwe_q, hwe_d;
    logic [DATA_W-1:0] rdata_q, hrdata_q;
    logic              hack_q, mis_q;
    logic [31:0]       rdc_q, wrc_q;

    logic [DATA_W-1:0] mem [DEPTH];

    logic            avs_req;
    logic [WA_W-1:0] avs_waddr;
    logic [WA_W-1:0] rd_addr;

    assign avs_req   = bus.avs_read | bus.avs_write;
    assign avs_waddr = bus.avs_address[ADDR_W-1:OFF_W];

    assign bus.avs_waitrequest =
        reset | (avs_req & (state_q != S_ACK));
    assign bus.avs_readdata = rdata_q;
    assign bus.host_rdata   = hrdata_q;
    assign bus.host_ack     = hack_q;
    assign rd_count         = rdc_q;
    assign wr_count         = wrc_q;
    assign misalign_err     = mis_q;

    // With one wait state the read is issued straight from the bus.
    assign rd_addr = (state_q == S_IDLE) ? avs_waddr : addr_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        we_d     = we_q;
        haddr_d  = haddr_q;
        hwdata_d = hwdata_q;
        hwe_d    = hwe_q;
        unique case (state_q)
            S_IDLE: begin
                if (avs_req) begin
                    addr_d  = avs_waddr;
                    wdata_d = bus.avs_writedata;
                    be_d    = bus.avs_byteenable;
                    we_d    = bus.avs_write;
                    cnt_d   = CNT_INIT;
                    state_d = (CNT_INIT == 4'd0) ? S_ACK : S_WAIT;
                end else if (bus.host_req) begin
                    haddr_d  = bus.host_addr;
                    hwdata_d = bus.host_wdata;
                    hwe_d    = bus.host_we;
                    state_d  = S_HOST;
                end
            end
            S_WAIT: begin
                if (!avs_req) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_d == 4'd0) state_d = S_ACK;
                end
            end
            S_ACK:   state_d = S_IDLE;
            S_HOST:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
            we_q     <= 1'b0;
            haddr_q  <= '0;
            hwdata_q <= '0;
            hwe_q    <= 1'b0;
            rdata_q  <= '0;
            hrdata_q <= '0;
            hack_q   <= 1'b0;
            mis_q    <= 1'b0;
            rdc_q    <= '0;
            wrc_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
            we_q     <= we_d;
            haddr_q  <= haddr_d;
            hwdata_q <= hwdata_d;
            hwe_q    <= hwe_d;
            hack_q   <= (state_d == S_HOST);
            if (state_d == S_ACK && !we_d)
                rdata_q <= mem[rd_addr];
            if (state_q == S_IDLE && state_d == S_HOST && !bus.host_we)
                hrdata_q <= mem[bus.host_addr];
            if (state_q == S_IDLE && avs_req &&
                bus.avs_address[OFF_W-1:0] != '0)
                mis_q <= 1'b1;
            if (state_q == S_ACK) begin
                if (we_q && wrc_q != 32'hFFFF_FFFF)
                    wrc_q <= wrc_q + 32'd1;
                if (!we_q && rdc_q != 32'hFFFF_FFFF)
                    rdc_q <= rdc_q + 32'd1;
            end
        end
    end

    // RAM is not reset; reset forces IDLE so nothing commits.
    always_ff @(posedge clk) begin
        if (state_q == S_ACK && we_q) begin
            for (int i = 0; i < BE_W; i++)
                if (be_q[i])
                    mem[addr_q][i*8 +: 8] <= wdata_q[i*8 +: 8];
        end
        if (state_q == S_HOST && hwe_q)
            mem[haddr_q] <= hwdata_q;
    end
endmodule

// File: tb/tb_avs_array_mem_responder.sv
// Directed bench: A instance has 2 wait states,
// B instance has 3 wait states.
module tb_avs_array_mem_responder;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int total = 0;
    int bad = 0;

    logic [31:0] rdc_a, wrc_a, rdc_b, wrc_b;
    logic        mis_a, mis_b;

    avs_array_mem_responder_if #(.DATA_W(64), .ADDR_W(13)) ia ();
    avs_array_mem_responder_if #(.DATA_W(64), .ADDR_W(13)) ib ();

    avs_array_mem_responder #(
        .DATA_W(64), .ADDR_W(13), .WAIT_STATES(2)
    ) dut_a (
        .clk(clk), .reset(reset), .bus(ia),
        .rd_count(rdc_a), .wr_count(wrc_a), .misalign_err(mis_a)
    );

    avs_array_mem_responder #(
        .DATA_W(64), .ADDR_W(13), .WAIT_STATES(3)
    ) dut_b (
        .clk(clk), .reset(reset), .bus(ib),
        .rd_count(rdc_b), .wr_count(wrc_b), .misalign_err(mis_b)
    );

    always #5 clk = ~clk;

    task automatic set_avs(input bit sel, input bit r, input bit w,
                           input logic [12:0] a, input logic [63:0] d,
                           input logic [7:0] be);
        if (sel) begin
            ib.avs_read = r; ib.avs_write = w; ib.avs_address = a;
            ib.avs_writedata = d; ib.avs_byteenable = be;
        end else begin
            ia.avs_read = r; ia.avs_write = w; ia.avs_address = a;
            ia.avs_writedata = d; ia.avs_byteenable = be;
        end
    endtask

    task automatic avs_op(input bit sel, input bit we,
                          input logic [12:0] a, input logic [63:0] d,
                          input logic [7:0] be,
                          output logic [63:0] rd, output int n);
        @(negedge clk);
        set_avs(sel, !we, we, a, d, be);
        n = 0;
        #1;
        while ((sel ? ib.avs_waitrequest : ia.avs_waitrequest) && n < 40) begin
            n++;
            @(negedge clk);
            #1;
        end
        rd = sel ? ib.avs_readdata : ia.avs_readdata;
        set_avs(sel, 1'b0, 1'b0, a, d, be);
        if (n >= 40) begin
            total++; bad++;
            $display("FAIL avs_timeout got=%0d want<40", n);
        end
    endtask

    task automatic host_op(input bit sel, input bit we,
                           input logic [9:0] a, input logic [63:0] d,
                           output logic [63:0] rd);
        int n;
        @(negedge clk);
        if (sel) begin
            ib.host_req = 1; ib.host_we = we; ib.host_addr = a; ib.host_wdata = d;
        end else begin
            ia.host_req = 1; ia.host_we = we; ia.host_addr = a; ia.host_wdata = d;
        end
        n = 0;
        rd = '0;
        do begin
            @(negedge clk);
            n++;
        end while (!(sel ? ib.host_ack : ia.host_ack) && n < 40);
        rd = sel ? ib.host_rdata : ia.host_rdata;
        if (sel) ib.host_req = 0;
        else ia.host_req = 0;
        if (n >= 40) begin
            total++; bad++;
            $display("FAIL host_timeout got=%0d want<40", n);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++;
        if (ia.avs_waitrequest !== 1'b1) begin
            bad++; $display("FAIL rst_waitreq got=%b want=1", ia.avs_waitrequest);
        end
        total++;
        if ({rdc_a, wrc_a} !== 64'd0 || mis_a !== 1'b0) begin
            bad++; $display("FAIL rst_status got=%h/%h/%b want=0", rdc_a, wrc_a, mis_a);
        end
        total++;
        if (ia.avs_readdata !== 64'd0 || ia.host_rdata !== 64'd0 || ia.host_ack !== 1'b0) begin
            bad++; $display("FAIL rst_outputs got=%h/%h/%b want=0",
                            ia.avs_readdata, ia.host_rdata, ia.host_ack);
        end
        reset = 0;
        @(negedge clk);
        total++;
        if (ia.avs_waitrequest !== 1'b0) begin
            bad++; $display("FAIL idle_waitreq got=%b want=0", ia.avs_waitrequest);
        end
    endtask

    task automatic test_read_latency();
        logic [63:0] rd;
        int n;
        host_op(0, 1, 10'd5, 64'h1122334455667788, rd);
        avs_op(0, 0, 13'h028, '0, 8'h00, rd, n);
        total++;
        if (n !== 2) begin
            bad++; $display("FAIL rd_wait_cycles got=%0d want=2", n);
        end
        total++;
        if (rd !== 64'h1122334455667788) begin
            bad++; $display("FAIL rd_data got=%h want=1122334455667788", rd);
        end
        @(negedge clk);
        total++;
        if (rdc_a !== 32'd1) begin
            bad++; $display("FAIL rd_count1 got=%0d want=1", rdc_a);
        end
        total++;
        if (ia.avs_readdata !== 64'h1122334455667788) begin
            bad++; $display("FAIL rd_hold got=%h want=1122334455667788", ia.avs_readdata);
        end
    endtask

    task automatic test_byteenable();
        logic [63:0] rd;
        int n;
        avs_op(0, 1, 13'h028, 64'hAAAAAAAAAAAAAAAA, 8'h0F, rd, n);
        total++;
        if (n !== 2) begin
            bad++; $display("FAIL wr_wait_cycles got=%0d want=2", n);
        end
        @(negedge clk);
        total++;
        if (wrc_a !== 32'd1) begin
            bad++; $display("FAIL wr_count1 got=%0d want=1", wrc_a);
        end
        host_op(0, 0, 10'd5, '0, rd);
        total++;
        if (rd !== 64'h11223344AAAAAAAA) begin
            bad++; $display("FAIL be_merge got=%h want=11223344aaaaaaaa", rd);
        end
    endtask

    task automatic test_arbitration();
        logic [63:0] rd, rdv, hr;
        int avs_c, ack_c, acks;
        host_op(0, 1, 10'd0, 64'hDEADBEEF00000001, rd);
        @(negedge clk);
        ia.avs_read = 1; ia.avs_address = 13'h028;
        ia.host_req = 1; ia.host_we = 0; ia.host_addr = 10'd0;
        avs_c = -1; ack_c = -1; acks = 0; rdv = '0; hr = '0;
        for (int c = 0; c < 10; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (ia.avs_read && !ia.avs_waitrequest) begin
                avs_c = c; rdv = ia.avs_readdata; ia.avs_read = 0;
            end
            if (ia.host_ack) begin
                acks++; ack_c = c; hr = ia.host_rdata; ia.host_req = 0;
            end
        end
        total++;
        if (avs_c !== 2) begin
            bad++; $display("FAIL arb_avs_first got=%0d want=2", avs_c);
        end
        total++;
        if (ack_c - avs_c !== 2) begin
            bad++; $display("FAIL arb_ack_gap got=%0d want=2", ack_c - avs_c);
        end
        total++;
        if (acks !== 1) begin
            bad++; $display("FAIL arb_ack_pulses got=%0d want=1", acks);
        end
        total++;
        if (rdv !== 64'h11223344AAAAAAAA || hr !== 64'hDEADBEEF00000001) begin
            bad++; $display("FAIL arb_data got=%h/%h want=11223344aaaaaaaa/deadbeef00000001", rdv, hr);
        end
        total++;
        if (rdc_a !== 32'd2) begin
            bad++; $display("FAIL rd_count2 got=%0d want=2", rdc_a);
        end
    endtask

    task automatic test_misalign();
        logic [63:0] rd;
        int n;
        total++;
        if (mis_a !== 1'b0) begin
            bad++; $display("FAIL mis_pre got=%b want=0", mis_a);
        end
        avs_op(0, 0, 13'h02B, '0, 8'h00, rd, n);
        @(negedge clk);
        total++;
        if (mis_a !== 1'b1) begin
            bad++; $display("FAIL mis_set got=%b want=1", mis_a);
        end
        total++;
        if (rd !== 64'h11223344AAAAAAAA) begin
            bad++; $display("FAIL mis_data got=%h want=11223344aaaaaaaa", rd);
        end
        avs_op(0, 0, 13'h000, '0, 8'h00, rd, n);
        @(negedge clk);
        total++;
        if (mis_a !== 1'b1 || rd !== 64'hDEADBEEF00000001) begin
            bad++; $display("FAIL mis_sticky got=%b/%h want=1/deadbeef00000001", mis_a, rd);
        end
        total++;
        if (rdc_a !== 32'd4) begin
            bad++; $display("FAIL rd_count4 got=%0d want=4", rdc_a);
        end
    endtask

    task automatic test_abort();
        logic [63:0] rd;
        int n;
        host_op(1, 1, 10'd7, 64'h0123456789ABCDEF, rd);
        avs_op(1, 1, 13'h030, 64'h5555555555555555, 8'hFF, rd, n);
        total++;
        if (n !== 3) begin
            bad++; $display("FAIL b_wait_cycles got=%0d want=3", n);
        end
        @(negedge clk);
        total++;
        if (wrc_b !== 32'd1) begin
            bad++; $display("FAIL b_wr_count got=%0d want=1", wrc_b);
        end
        set_avs(1, 0, 1, 13'h038, 64'hFFFFFFFFFFFFFFFF, 8'hFF);
        @(negedge clk);
        #1 reset = 1;
        #1;
        total++;
        if (ib.avs_waitrequest !== 1'b1) begin
            bad++; $display("FAIL rst_mid_waitreq got=%b want=1", ib.avs_waitrequest);
        end
        @(negedge clk);
        @(negedge clk);
        set_avs(1, 0, 0, 13'h038, '0, 8'h00);
        reset = 0;
        @(negedge clk);
        total++;
        if ({rdc_b, wrc_b, rdc_a} !== 96'd0 || ib.host_ack !== 1'b0) begin
            bad++; $display("FAIL rst_mid_counts got=%0d/%0d/%0d want=0", rdc_b, wrc_b, rdc_a);
        end
        host_op(1, 0, 10'd7, '0, rd);
        total++;
        if (rd !== 64'h0123456789ABCDEF) begin
            bad++; $display("FAIL rst_no_commit got=%h want=0123456789abcdef", rd);
        end
        host_op(1, 0, 10'd6, '0, rd);
        total++;
        if (rd !== 64'h5555555555555555) begin
            bad++; $display("FAIL ram_kept got=%h want=5555555555555555", rd);
        end
        @(negedge clk);
        set_avs(1, 0, 1, 13'h038, 64'hFFFFFFFFFFFFFFFF, 8'hFF);
        @(negedge clk);
        #1;
        total++;
        if (ib.avs_waitrequest !== 1'b1) begin
            bad++; $display("FAIL drop_in_wait got=%b want=1", ib.avs_waitrequest);
        end
        set_avs(1, 0, 0, 13'h038, '0, 8'h00);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        total++;
        if (wrc_b !== 32'd0) begin
            bad++; $display("FAIL drop_wr_count got=%0d want=0", wrc_b);
        end
        host_op(1, 0, 10'd7, '0, rd);
        total++;
        if (rd !== 64'h0123456789ABCDEF) begin
            bad++; $display("FAIL drop_no_commit got=%h want=0123456789abcdef", rd);
        end
        avs_op(1, 0, 13'h038, '0, 8'h00, rd, n);
        @(negedge clk);
        total++;
        if (n !== 3 || rd !== 64'h0123456789ABCDEF || rdc_b !== 32'd1) begin
            bad++; $display("FAIL b_read_after got=%0d/%h/%0d want=3/0123456789abcdef/1",
                            n, rd, rdc_b);
        end
    endtask

    initial begin
        set_avs(0, 0, 0, '0, '0, '0);
        set_avs(1, 0, 0, '0, '0, '0);
        ia.host_req = 0; ia.host_we = 0; ia.host_addr = '0; ia.host_wdata = '0;
        ib.host_req = 0; ib.host_we = 0; ib.host_addr = '0; ib.host_wdata = '0;
        test_reset();
        test_read_latency();
        test_byteenable();
        test_arbitration();
        test_misalign();
        test_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
